// File: rtl/pipeline_ex_stage_m.sv
// pipeline_ex_stage_m
// Execute stage of the 5-stage RV64 pipeline. It contains the single-cycle
// ALU and branch-compare path, JAL/JALR target resolution, and an iterative
// radix-2 M-extension unit covering MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Every EX/MEM output is registered.
//
// Ports
//   clk, reset (async, active-low)
//   valid_ID, flush_EX                     slot valid / kill the instruction in EX
//   reg_data1_EX, reg_data2_EX, imm_EX,    operands, immediate, PC
//   pc_EX
//   rd_EX, opcode_EX, funct3_EX,           instruction fields
//   funct7_EX
//   alu_ctrl, alu_a_sel, alu_b_sel         ALU function and operand selects
//   rf_wr_en_ID, rf_wr_sel_ID,             WB/MEM controls, passed through
//   dm_rd_ctrl_ID, dm_wr_ctrl_ID
//   do_jump, BrType                        jump request and branch type
//   stall_EX                               combinational hold request to upstream
//   valid_MEM, pc_out, rd_MEM,             EX/MEM register outputs
//   reg_data2_MEM, rf_wr_en_EX,
//   rf_wr_sel_EX, dm_rd_ctrl_EX,
//   dm_wr_ctrl_EX, alu_result_EX,
//   branch_taken_EX, branch_target_EX
//
// alu_ctrl: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//           8 OR, 9 AND, 10 pass B (LUI); any other code gives 0.
// BrType:   000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
module pipeline_ex_stage_m #(
   parameter int XLEN  = 64,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_ID,
   input  logic            flush_EX,
   input  logic [XLEN-1:0] reg_data1_EX,
   input  logic [XLEN-1:0] reg_data2_EX,
   input  logic [XLEN-1:0] imm_EX,
   input  logic [XLEN-1:0] pc_EX,
   input  logic [4:0]      rd_EX,
   input  logic [6:0]      opcode_EX,
   input  logic [2:0]      funct3_EX,
   input  logic [6:0]      funct7_EX,
   input  logic [3:0]      alu_ctrl,
   input  logic            alu_a_sel,
   input  logic            alu_b_sel,
   input  logic            rf_wr_en_ID,
   input  logic [1:0]      rf_wr_sel_ID,
   input  logic [2:0]      dm_rd_ctrl_ID,
   input  logic [1:0]      dm_wr_ctrl_ID,
   input  logic            do_jump,
   input  logic [2:0]      BrType,
   output logic            stall_EX,
   output logic            valid_MEM,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rd_MEM,
   output logic [XLEN-1:0] reg_data2_MEM,
   output logic            rf_wr_en_EX,
   output logic [1:0]      rf_wr_sel_EX,
   output logic [2:0]      dm_rd_ctrl_EX,
   output logic [1:0]      dm_wr_ctrl_EX,
   output logic [XLEN-1:0] alu_result_EX,
   output logic            branch_taken_EX,
   output logic [XLEN-1:0] branch_target_EX
);

   localparam int SH_W = $clog2(XLEN);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} m_state_e;

   m_state_e          state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d;    // product high half / partial remainder
   logic [XLEN-1:0]   lo_q, lo_d;    // multiplier+product low half / dividend+quotient
   logic [XLEN-1:0]   b_q, b_d;      // multiplicand / divisor magnitude
   logic [2:0]        op_q, op_d;
   logic              neg_q, neg_d;

   logic [XLEN-1:0]   alu_a_s, alu_b_s, alu_res_s;
   logic              br_e_s, br_taken_s;
   logic [XLEN-1:0]   br_target_s;
   logic              is_m_s, is_div_s, sgn_a_s, sgn_b_s, a_neg_s, b_neg_s, neg_s;
   logic [XLEN-1:0]   abs_a_s, abs_b_s;
   logic              div_zero_s, div_ovf_s;
   logic [XLEN:0]     mul_sum_s, div_shift_s;
   logic [XLEN-1:0]   div_rem_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   m_result_s;
   logic              stall_s, load_s;

   // ALU operand selection and function
   always_comb begin
      alu_a_s = alu_a_sel ? reg_data1_EX : pc_EX;
      alu_b_s = alu_b_sel ? imm_EX : reg_data2_EX;
      case (alu_ctrl)
         4'd0:    alu_res_s = alu_a_s + alu_b_s;
         4'd1:    alu_res_s = alu_a_s - alu_b_s;
         4'd2:    alu_res_s = alu_a_s << alu_b_s[SH_W-1:0];
         4'd3:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
         4'd4:    alu_res_s = {{(XLEN-1){1'b0}}, (alu_a_s < alu_b_s)};
         4'd5:    alu_res_s = alu_a_s ^ alu_b_s;
         4'd6:    alu_res_s = alu_a_s >> alu_b_s[SH_W-1:0];
         4'd7:    alu_res_s = $unsigned($signed(alu_a_s) >>> alu_b_s[SH_W-1:0]);
         4'd8:    alu_res_s = alu_a_s | alu_b_s;
         4'd9:    alu_res_s = alu_a_s & alu_b_s;
         4'd10:   alu_res_s = alu_b_s;
         default: alu_res_s = {XLEN{1'b0}};
      endcase
   end

   // Branch compare and control-transfer target resolution
   always_comb begin
      case (BrType)
         3'b000:  br_e_s = (reg_data1_EX == reg_data2_EX);
         3'b001:  br_e_s = (reg_data1_EX != reg_data2_EX);
         3'b100:  br_e_s = ($signed(reg_data1_EX) < $signed(reg_data2_EX));
         3'b101:  br_e_s = ($signed(reg_data1_EX) >= $signed(reg_data2_EX));
         3'b110:  br_e_s = (reg_data1_EX < reg_data2_EX);
         3'b111:  br_e_s = (reg_data1_EX >= reg_data2_EX);
         default: br_e_s = 1'b0;
      endcase
      br_taken_s  = 1'b0;
      br_target_s = {XLEN{1'b0}};
      if (valid_ID) begin
         case (opcode_EX)
            7'b1100011: begin
               br_taken_s  = br_e_s || do_jump;
               br_target_s = pc_EX + imm_EX;
            end
            7'b1101111: begin
               br_taken_s  = 1'b1;
               br_target_s = pc_EX + imm_EX;
            end
            7'b1100111: begin
               br_taken_s  = 1'b1;
               br_target_s = (reg_data1_EX + imm_EX) & ~{{(XLEN-1){1'b0}}, 1'b1};
            end
            default: begin
               br_taken_s  = 1'b0;
               br_target_s = {XLEN{1'b0}};
            end
         endcase
      end else begin
         br_taken_s  = 1'b0;
         br_target_s = {XLEN{1'b0}};
      end
   end

   // M-op decode, operand magnitudes and result sign
   always_comb begin
      is_m_s   = valid_ID && (opcode_EX == 7'b0110011) && (funct7_EX == 7'b0000001);
      is_div_s = funct3_EX[2];
      // Divide ops are signed when funct3[0]=0; MULHU is the only fully unsigned multiply.
      sgn_a_s  = is_div_s ? !funct3_EX[0] : (funct3_EX[1:0] != 2'b11);
      sgn_b_s  = is_div_s ? !funct3_EX[0] : !funct3_EX[1];
      a_neg_s  = sgn_a_s && reg_data1_EX[XLEN-1];
      b_neg_s  = sgn_b_s && reg_data2_EX[XLEN-1];
      abs_a_s  = a_neg_s ? -reg_data1_EX : reg_data1_EX;
      abs_b_s  = b_neg_s ? -reg_data2_EX : reg_data2_EX;
      // REM/REMU (funct3[2:1]=11) follow the dividend sign; all others the xor of signs.
      neg_s    = (is_div_s && funct3_EX[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
      div_zero_s = (reg_data2_EX == {XLEN{1'b0}});
      div_ovf_s  = !funct3_EX[0] && (reg_data1_EX == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (reg_data2_EX == {XLEN{1'b1}});
   end

   // Radix-2 datapath step terms and final sign correction
   always_comb begin
      mul_sum_s   = {1'b0, hi_q} + {1'b0, b_q};
      div_shift_s = {hi_q, lo_q[XLEN-1]};
      // The partial remainder is always below the divisor, so a successful
      // trial subtraction fits in XLEN bits.
      div_rem_s   = div_shift_s[XLEN-1:0] - b_q;
      prod_s      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      if (op_q[2]) begin
         if (op_q[1]) begin
            m_result_s = neg_q ? -hi_q : hi_q;
         end else begin
            m_result_s = neg_q ? -lo_q : lo_q;
         end
      end else if (op_q == 3'b000) begin
         m_result_s = prod_s[XLEN-1:0];
      end else begin
         m_result_s = prod_s[2*XLEN-1:XLEN];
      end
   end

   assign stall_s  = is_m_s && (state_q != ST_DONE) && !flush_EX;
   assign load_s   = valid_ID && !flush_EX && !stall_s;
   assign stall_EX = stall_s;

   // M-unit next-state, counter and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      op_d    = op_q;
      neg_d   = neg_q;
      if (flush_EX) begin
         state_d = ST_IDLE;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (is_m_s) begin
                  op_d = funct3_EX;
                  if (is_div_s && div_zero_s) begin
                     hi_d    = reg_data1_EX;
                     lo_d    = {XLEN{1'b1}};
                     neg_d   = 1'b0;
                     state_d = ST_DONE;
                  end else if (is_div_s && div_ovf_s) begin
                     hi_d    = {XLEN{1'b0}};
                     lo_d    = reg_data1_EX;
                     neg_d   = 1'b0;
                     state_d = ST_DONE;
                  end else begin
                     hi_d    = {XLEN{1'b0}};
                     lo_d    = is_div_s ? abs_a_s : abs_b_s;
                     b_d     = is_div_s ? abs_b_s : abs_a_s;
                     neg_d   = neg_s;
                     cnt_d   = CNT_W'(XLEN);
                     state_d = ST_BUSY;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (!is_m_s) begin
                  // The instruction left EX without a flush; drop the op.
                  state_d = ST_IDLE;
                  cnt_d   = {CNT_W{1'b0}};
               end else begin
                  if (op_q[2]) begin
                     if (div_shift_s >= {1'b0, b_q}) begin
                        hi_d = div_rem_s;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                     end else begin
                        hi_d = div_shift_s[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                     end
                  end else if (lo_q[0]) begin
                     hi_d = mul_sum_s[XLEN:1];
                     lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
                  end else begin
                     hi_d = {1'b0, hi_q[XLEN-1:1]};
                     lo_d = {hi_q[0], lo_q[XLEN-1:1]};
                  end
                  cnt_d   = cnt_q - CNT_W'(1);
                  state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_BUSY;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // M-unit state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         hi_q    <= {XLEN{1'b0}};
         lo_q    <= {XLEN{1'b0}};
         b_q     <= {XLEN{1'b0}};
         op_q    <= 3'b000;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
      end
   end

   // EX/MEM pipeline register: full load, or bubble with data fields held
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_MEM        <= 1'b0;
         pc_out           <= {XLEN{1'b0}};
         rd_MEM           <= 5'd0;
         reg_data2_MEM    <= {XLEN{1'b0}};
         rf_wr_en_EX      <= 1'b0;
         rf_wr_sel_EX     <= 2'd0;
         dm_rd_ctrl_EX    <= 3'd0;
         dm_wr_ctrl_EX    <= 2'd0;
         alu_result_EX    <= {XLEN{1'b0}};
         branch_taken_EX  <= 1'b0;
         branch_target_EX <= {XLEN{1'b0}};
      end else if (load_s) begin
         valid_MEM        <= 1'b1;
         pc_out           <= pc_EX;
         rd_MEM           <= rd_EX;
         reg_data2_MEM    <= reg_data2_EX;
         rf_wr_en_EX      <= rf_wr_en_ID;
         rf_wr_sel_EX     <= rf_wr_sel_ID;
         dm_rd_ctrl_EX    <= dm_rd_ctrl_ID;
         dm_wr_ctrl_EX    <= dm_wr_ctrl_ID;
         alu_result_EX    <= is_m_s ? m_result_s : alu_res_s;
         branch_taken_EX  <= br_taken_s;
         branch_target_EX <= br_target_s;
      end else begin
         valid_MEM        <= 1'b0;
         rf_wr_en_EX      <= 1'b0;
         dm_rd_ctrl_EX    <= 3'd0;
         dm_wr_ctrl_EX    <= 2'd0;
         branch_taken_EX  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_ex_stage_m.sv
// Directed testbench for pipeline_ex_stage_m (XLEN = 64).
module tb_pipeline_ex_stage_m;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            valid_ID, flush_EX;
   logic [XLEN-1:0] reg_data1_EX, reg_data2_EX, imm_EX, pc_EX;
   logic [4:0]      rd_EX;
   logic [6:0]      opcode_EX, funct7_EX;
   logic [2:0]      funct3_EX;
   logic [3:0]      alu_ctrl;
   logic            alu_a_sel, alu_b_sel, rf_wr_en_ID;
   logic [1:0]      rf_wr_sel_ID, dm_wr_ctrl_ID;
   logic [2:0]      dm_rd_ctrl_ID, BrType;
   logic            do_jump;
   logic            stall_EX, valid_MEM, rf_wr_en_EX, branch_taken_EX;
   logic [XLEN-1:0] pc_out, reg_data2_MEM, alu_result_EX, branch_target_EX;
   logic [4:0]      rd_MEM;
   logic [1:0]      rf_wr_sel_EX, dm_wr_ctrl_EX;
   logic [2:0]      dm_rd_ctrl_EX;

   int n_checks = 0;
   int n_fail   = 0;

   pipeline_ex_stage_m #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .valid_ID(valid_ID), .flush_EX(flush_EX),
      .reg_data1_EX(reg_data1_EX), .reg_data2_EX(reg_data2_EX), .imm_EX(imm_EX),
      .pc_EX(pc_EX), .rd_EX(rd_EX), .opcode_EX(opcode_EX), .funct3_EX(funct3_EX),
      .funct7_EX(funct7_EX), .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .rf_wr_en_ID(rf_wr_en_ID), .rf_wr_sel_ID(rf_wr_sel_ID),
      .dm_rd_ctrl_ID(dm_rd_ctrl_ID), .dm_wr_ctrl_ID(dm_wr_ctrl_ID), .do_jump(do_jump),
      .BrType(BrType), .stall_EX(stall_EX), .valid_MEM(valid_MEM), .pc_out(pc_out),
      .rd_MEM(rd_MEM), .reg_data2_MEM(reg_data2_MEM), .rf_wr_en_EX(rf_wr_en_EX),
      .rf_wr_sel_EX(rf_wr_sel_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX),
      .dm_wr_ctrl_EX(dm_wr_ctrl_EX), .alu_result_EX(alu_result_EX),
      .branch_taken_EX(branch_taken_EX), .branch_target_EX(branch_target_EX)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      valid_ID = 1'b0; flush_EX = 1'b0;
      reg_data1_EX = 64'd0; reg_data2_EX = 64'd0; imm_EX = 64'd0; pc_EX = 64'd0;
      rd_EX = 5'd0; opcode_EX = 7'd0; funct3_EX = 3'd0; funct7_EX = 7'd0;
      alu_ctrl = 4'd0; alu_a_sel = 1'b1; alu_b_sel = 1'b0;
      rf_wr_en_ID = 1'b0; rf_wr_sel_ID = 2'd0; dm_rd_ctrl_ID = 3'd0; dm_wr_ctrl_ID = 2'd0;
      do_jump = 1'b0; BrType = 3'd0;
   endtask

   // Register-register OP instruction (ALU ADD when funct7=0, M op when funct7=1)
   task automatic set_rop(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b);
      clear_in();
      valid_ID = 1'b1; opcode_EX = 7'b0110011; funct7_EX = f7; funct3_EX = f3;
      reg_data1_EX = a; reg_data2_EX = b; pc_EX = 64'h40; rd_EX = 5'd10;
      rf_wr_en_ID = 1'b1; rf_wr_sel_ID = 2'd1;
   endtask

   // Hold the current M op until stall drops, then take the DONE edge.
   task automatic run_mop(output int stalls, output int bubble_bad, output bit timed_out);
      bit done;
      done = 1'b0; stalls = 0; bubble_bad = 0; timed_out = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         #1;
         if (stall_EX) begin
            tick();
            stalls++;
            if (valid_MEM !== 1'b0 || rf_wr_en_EX !== 1'b0) bubble_bad++;
         end else begin
            tick();
            done = 1'b1;
         end
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      clear_in();
      reset = 1'b0;
      #2;
      n_checks++; if (valid_MEM !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_MEM); end
      n_checks++; if (alu_result_EX !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", alu_result_EX); end
      n_checks++; if (stall_EX !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_EX); end
      n_checks++; if (dut.cnt_q !== 7'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_add();
      set_rop(7'd0, 3'd0, 64'd5, 64'd7);
      #1;
      n_checks++; if (stall_EX !== 1'b0) begin n_fail++; $display("FAIL add_stall: got %b expected 0", stall_EX); end
      tick();
      n_checks++; if (alu_result_EX !== 64'd12) begin n_fail++; $display("FAIL add_result: got %h expected c", alu_result_EX); end
      n_checks++; if (valid_MEM !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", valid_MEM); end
      n_checks++; if (rd_MEM !== 5'd10 || pc_out !== 64'h40 || reg_data2_MEM !== 64'd7)
         begin n_fail++; $display("FAIL add_passthru: got rd=%0d pc=%h rs2=%h expected 10 40 7", rd_MEM, pc_out, reg_data2_MEM); end
      // PC + imm selection
      alu_a_sel = 1'b0; alu_b_sel = 1'b1; imm_EX = 64'd4;
      tick();
      n_checks++; if (alu_result_EX !== 64'h44) begin n_fail++; $display("FAIL add_pc_imm: got %h expected 44", alu_result_EX); end
      clear_in();
      tick();
      n_checks++; if (valid_MEM !== 1'b0 || alu_result_EX !== 64'h44)
         begin n_fail++; $display("FAIL bubble_hold: got valid=%b res=%h expected 0 44", valid_MEM, alu_result_EX); end
   endtask

   task automatic test_m_ops();
      logic [2:0] f3; logic [63:0] a, b, exp; int exp_st; string nm;
      int st, bb; bit to;
      for (int i = 0; i < 13; i++) begin
         case (i)
            0:  begin nm = "mul";      f3 = 3'b000; a = 64'd7;  b = -64'd3; exp = 64'hFFFF_FFFF_FFFF_FFEB; exp_st = 65; end
            1:  begin nm = "div_by0";  f3 = 3'b100; a = 64'd100; b = 64'd0; exp = 64'hFFFF_FFFF_FFFF_FFFF; exp_st = 1; end
            2:  begin nm = "rem_by0";  f3 = 3'b110; a = 64'd100; b = 64'd0; exp = 64'd100; exp_st = 1; end
            3:  begin nm = "div_ovf";  f3 = 3'b100; a = 64'h8000_0000_0000_0000; b = -64'd1; exp = 64'h8000_0000_0000_0000; exp_st = 1; end
            4:  begin nm = "divu";     f3 = 3'b101; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd3; exp = 64'h5555_5555_5555_5555; exp_st = 65; end
            5:  begin nm = "rem_neg";  f3 = 3'b110; a = -64'd7; b = 64'd2; exp = 64'hFFFF_FFFF_FFFF_FFFF; exp_st = 65; end
            6:  begin nm = "mulhu";    f3 = 3'b011; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; exp = 64'hFFFF_FFFF_FFFF_FFFE; exp_st = 65; end
            7:  begin nm = "mulhsu";   f3 = 3'b010; a = -64'd1; b = 64'd2; exp = 64'hFFFF_FFFF_FFFF_FFFF; exp_st = 65; end
            8:  begin nm = "div_neg";  f3 = 3'b100; a = -64'd100; b = 64'd7; exp = 64'hFFFF_FFFF_FFFF_FFF2; exp_st = 65; end
            9:  begin nm = "remu";     f3 = 3'b111; a = 64'd100; b = 64'd7; exp = 64'd2; exp_st = 65; end
            10: begin nm = "mulh";     f3 = 3'b001; a = 64'h4000_0000_0000_0000; b = 64'd4; exp = 64'd1; exp_st = 65; end
            11: begin nm = "rem_ovf";  f3 = 3'b110; a = 64'h8000_0000_0000_0000; b = -64'd1; exp = 64'd0; exp_st = 1; end
            default: begin nm = "divu_by0"; f3 = 3'b101; a = 64'd5; b = 64'd0; exp = 64'hFFFF_FFFF_FFFF_FFFF; exp_st = 1; end
         endcase
         set_rop(7'b0000001, f3, a, b);
         run_mop(st, bb, to);
         clear_in();
         n_checks++; if (to) begin n_fail++; $display("FAIL %s_timeout: got no completion expected completion", nm); end
         n_checks++; if (st != exp_st) begin n_fail++; $display("FAIL %s_stall_cycles: got %0d expected %0d", nm, st, exp_st); end
         n_checks++; if (bb != 0) begin n_fail++; $display("FAIL %s_stall_bubble: got %0d non-bubble cycles expected 0", nm, bb); end
         n_checks++; if (alu_result_EX !== exp) begin n_fail++; $display("FAIL %s_result: got %h expected %h", nm, alu_result_EX, exp); end
         n_checks++; if (valid_MEM !== 1'b1 || rf_wr_en_EX !== 1'b1)
            begin n_fail++; $display("FAIL %s_valid: got valid=%b wr=%b expected 1 1", nm, valid_MEM, rf_wr_en_EX); end
      end
   endtask

   task automatic test_back_to_back();
      int st, bb; bit to;
      set_rop(7'b0000001, 3'b000, 64'd6, 64'd7);
      run_mop(st, bb, to);
      n_checks++; if (st != 65 || alu_result_EX !== 64'd42)
         begin n_fail++; $display("FAIL b2b_first: got stalls=%0d res=%h expected 65 2a", st, alu_result_EX); end
      set_rop(7'b0000001, 3'b101, 64'd42, 64'd5);
      run_mop(st, bb, to);
      n_checks++; if (st != 65 || alu_result_EX !== 64'd8 || to)
         begin n_fail++; $display("FAIL b2b_second: got stalls=%0d res=%h expected 65 8", st, alu_result_EX); end
      clear_in();
   endtask

   task automatic test_flush();
      int st, bb; bit to;
      set_rop(7'b0000001, 3'b100, 64'd100, 64'd7);
      #1;
      n_checks++; if (stall_EX !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b expected 1", stall_EX); end
      tick();
      repeat (9) tick();
      flush_EX = 1'b1;
      #1;
      n_checks++; if (stall_EX !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stall_EX); end
      tick();
      flush_EX = 1'b0;
      n_checks++; if (valid_MEM !== 1'b0 || rf_wr_en_EX !== 1'b0)
         begin n_fail++; $display("FAIL flush_bubble: got valid=%b wr=%b expected 0 0", valid_MEM, rf_wr_en_EX); end
      n_checks++; if (dut.cnt_q !== 7'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 0", dut.cnt_q); end
      // The same DIV restarts from scratch after the flush.
      run_mop(st, bb, to);
      n_checks++; if (st != 65 || alu_result_EX !== 64'd14 || to)
         begin n_fail++; $display("FAIL flush_restart: got stalls=%0d res=%h expected 65 e", st, alu_result_EX); end
      set_rop(7'd0, 3'd0, 64'd5, 64'd7);
      #1;
      n_checks++; if (stall_EX !== 1'b0) begin n_fail++; $display("FAIL flush_add_stall: got %b expected 0", stall_EX); end
      tick();
      n_checks++; if (alu_result_EX !== 64'd12 || valid_MEM !== 1'b1)
         begin n_fail++; $display("FAIL flush_add: got res=%h valid=%b expected c 1", alu_result_EX, valid_MEM); end
      clear_in();
   endtask

   task automatic test_jumps();
      logic [6:0] op; logic [2:0] bt; logic [63:0] r1, r2, im, pc; logic dj, exp_t; logic [63:0] exp_tg; string nm;
      for (int i = 0; i < 8; i++) begin
         dj = 1'b0; bt = 3'b000; r2 = 64'd0;
         case (i)
            0: begin nm = "jalr";     op = 7'b1100111; r1 = 64'h1001; im = 64'd4; pc = 64'h500; exp_t = 1'b1; exp_tg = 64'h1004; end
            1: begin nm = "beq";      op = 7'b1100011; r1 = 64'd5; r2 = 64'd5; im = -64'd8; pc = 64'h100; exp_t = 1'b1; exp_tg = 64'hF8; end
            2: begin nm = "bne_eq";   op = 7'b1100011; bt = 3'b001; r1 = 64'd5; r2 = 64'd5; im = -64'd8; pc = 64'h100; exp_t = 1'b0; exp_tg = 64'hF8; end
            3: begin nm = "bne_jump"; op = 7'b1100011; bt = 3'b001; dj = 1'b1; r1 = 64'd5; r2 = 64'd5; im = 64'd8; pc = 64'h100; exp_t = 1'b1; exp_tg = 64'h108; end
            4: begin nm = "jal";      op = 7'b1101111; r1 = 64'd0; im = 64'h10; pc = 64'h200; exp_t = 1'b1; exp_tg = 64'h210; end
            5: begin nm = "blt";      op = 7'b1100011; bt = 3'b100; r1 = -64'd1; r2 = 64'd1; im = 64'h20; pc = 64'h300; exp_t = 1'b1; exp_tg = 64'h320; end
            6: begin nm = "bltu";     op = 7'b1100011; bt = 3'b110; r1 = -64'd1; r2 = 64'd1; im = 64'h20; pc = 64'h300; exp_t = 1'b0; exp_tg = 64'h320; end
            default: begin nm = "non_branch"; op = 7'b0010011; r1 = 64'd1; im = 64'h20; pc = 64'h300; exp_t = 1'b0; exp_tg = 64'd0; end
         endcase
         clear_in();
         valid_ID = 1'b1; opcode_EX = op; BrType = bt; do_jump = dj;
         reg_data1_EX = r1; reg_data2_EX = r2; imm_EX = im; pc_EX = pc;
         tick();
         n_checks++; if (branch_taken_EX !== exp_t || branch_target_EX !== exp_tg)
            begin n_fail++; $display("FAIL %s: got taken=%b target=%h expected %b %h", nm, branch_taken_EX, branch_target_EX, exp_t, exp_tg); end
      end
      // Unqualified slot: no transfer reported
      valid_ID = 1'b0; opcode_EX = 7'b1101111;
      tick();
      n_checks++; if (branch_taken_EX !== 1'b0) begin n_fail++; $display("FAIL jal_invalid: got %b expected 0", branch_taken_EX); end
      clear_in();
   endtask

   task automatic test_reset_midop();
      set_rop(7'd0, 3'd0, 64'd5, 64'd7);
      tick();
      set_rop(7'b0000001, 3'b000, 64'd3, 64'd4);
      tick();
      tick();
      #2;
      reset = 1'b0;
      valid_ID = 1'b0;
      #1;
      n_checks++; if (alu_result_EX !== 64'd0 || valid_MEM !== 1'b0 || pc_out !== 64'd0 ||
                      rd_MEM !== 5'd0 || reg_data2_MEM !== 64'd0 || rf_wr_en_EX !== 1'b0)
         begin n_fail++; $display("FAIL midop_reset_outputs: got res=%h valid=%b pc=%h rd=%0d expected all zero", alu_result_EX, valid_MEM, pc_out, rd_MEM); end
      n_checks++; if (dut.cnt_q !== 7'd0 || stall_EX !== 1'b0)
         begin n_fail++; $display("FAIL midop_reset_fsm: got cnt=%0d stall=%b expected 0 0", dut.cnt_q, stall_EX); end
      #2;
      reset = 1'b1;
      clear_in();
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_m_ops();
      test_back_to_back();
      test_flush();
      test_jumps();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
